// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit processor: address/instruction widths and
// the fetch sequencer state encoding.
package cpu_pkg;

  localparam int CPU_AW = 8;
  localparam int CPU_DW = 8;

  typedef logic [CPU_AW-1:0] addr_t;
  typedef logic [CPU_DW-1:0] instr_t;

  // S_HOLD samples pc, S_FETCH waits for the read, S_DRAIN waits out a
  // read whose data was invalidated by a redirect.
  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: samples the program counter, runs a req/ack
// read with program memory and hands each byte to the decoder through a
// valid/ready instruction register. Branch redirects load the program
// counter and flush the instruction register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic          pc_cnt,
  output logic          pc_ld,
  output logic [AW-1:0] pc_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_valid,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic          capture;

  // A fetch completes only when the read returns and no redirect kills it.
  assign capture  = (state_q == S_FETCH) && mem_ack && !br_valid;

  assign mem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign mem_addr = addr_q;
  assign pc_cnt   = capture;
  assign pc_ld    = br_valid && rst_n;
  assign pc_addr  = br_target;
  assign ir_valid = ir_valid_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;

  // State, address and instruction registers; async reset aborts any read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLD;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Next-state logic; the address is only sampled in S_HOLD so it is stable while mem_req is high.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_HOLD: begin
        addr_d = pc;
        if ((!ir_valid_q || ir_ready) && !br_valid) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (br_valid)     state_d = mem_ack ? S_HOLD : S_DRAIN;
        else if (mem_ack) state_d = S_HOLD;
      end
      S_DRAIN: begin
        if (mem_ack) state_d = S_HOLD;
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Instruction register: a flush beats both capture and decoder acceptance.
  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (br_valid) begin
      ir_valid_d = 1'b0;
    end else if (capture) begin
      ir_d       = mem_rdata;
      ir_pc_d    = addr_q;
      ir_valid_d = 1'b1;
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. The bench plays both the
// program counter and program memory, so each vector lists the pc value and
// memory response for that cycle together with the expected outputs.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic       pc_cnt;
  logic       pc_ld;
  logic [7:0] pc_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       ir_valid;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_ready;
  logic       br_valid;
  logic [7:0] br_target;

  int vecCount  = 0;
  int failCount = 0;

  typedef struct {
    logic       rstN;
    logic [7:0] pc;
    logic       ack;
    logic [7:0] rdata;
    logic       ready;
    logic       br;
    logic [7:0] tgt;
    logic       expReq;
    logic [7:0] expAddr;
    logic       expCnt;
    logic       expLd;
    logic       expIv;
    logic [7:0] expIr;
    logic [7:0] expIrPc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .pc_cnt    (pc_cnt),
    .pc_ld     (pc_ld),
    .pc_addr   (pc_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_ready  (ir_ready),
    .br_valid  (br_valid),
    .br_target (br_target)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Appends one cycle: inputs first, then the expected outputs.
  task automatic addVec(input int r, input int p, input int a, input int d,
                        input int rdy, input int b, input int t,
                        input int eReq, input int eAddr, input int eCnt,
                        input int eLd, input int eIv, input int eIr,
                        input int eIrPc);
    vec_t v;
    v.rstN    = r[0];
    v.pc      = p[7:0];
    v.ack     = a[0];
    v.rdata   = d[7:0];
    v.ready   = rdy[0];
    v.br      = b[0];
    v.tgt     = t[7:0];
    v.expReq  = eReq[0];
    v.expAddr = eAddr[7:0];
    v.expCnt  = eCnt[0];
    v.expLd   = eLd[0];
    v.expIv   = eIv[0];
    v.expIr   = eIr[7:0];
    v.expIrPc = eIrPc[7:0];
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rstN;
    pc        = v.pc;
    mem_ack   = v.ack;
    mem_rdata = v.rdata;
    ir_ready  = v.ready;
    br_valid  = v.br;
    br_target = v.tgt;
  endtask

  // Compares the full output bundle {req,addr,cnt,ld,pc_addr,iv,ir,ir_pc}.
  task automatic checkOutput(input string name, input logic [35:0] exp);
    logic [35:0] got;
    got = {mem_req, mem_addr, pc_cnt, pc_ld, pc_addr, ir_valid, ir, ir_pc};
    vecCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got req=%0b addr=%02h cnt=%0b ld=%0b pc_addr=%02h iv=%0b ir=%02h ir_pc=%02h, expected req=%0b addr=%02h cnt=%0b ld=%0b pc_addr=%02h iv=%0b ir=%02h ir_pc=%02h",
               name, got[35], got[34:27], got[26], got[25], got[24:17], got[16], got[15:8], got[7:0],
               exp[35], exp[34:27], exp[26], exp[25], exp[24:17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; br_valid = 1'b0; br_target = '0;

    //      rst pc   ack rdata rdy br tgt    req addr cnt ld iv ir    irpc
    // reset: outputs idle, pc_ld suppressed, pc_addr follows br_target
    addVec(0, 'h00, 1, 'h00, 1, 0, 'h33,  0, 'h00, 0, 0, 0, 'h00, 'h00);
    addVec(0, 'h00, 0, 'h00, 1, 1, 'h44,  0, 'h00, 0, 0, 0, 'h00, 'h00);
    // zero-wait fetches of 0x00 and 0x01, one per two cycles
    addVec(1, 'h00, 0, 'h00, 1, 0, 'h00,  0, 'h00, 0, 0, 0, 'h00, 'h00);
    addVec(1, 'h00, 1, 'hA5, 1, 0, 'h00,  1, 'h00, 1, 0, 0, 'h00, 'h00);
    addVec(1, 'h01, 0, 'h00, 1, 0, 'h00,  0, 'h00, 0, 0, 1, 'hA5, 'h00);
    addVec(1, 'h01, 1, 'hA6, 1, 0, 'h00,  1, 'h01, 1, 0, 0, 'hA5, 'h00);
    addVec(1, 'h02, 0, 'h00, 1, 0, 'h00,  0, 'h01, 0, 0, 1, 'hA6, 'h01);
    // fetch of 0x02 with three wait cycles: req held 4 cycles, one pc_cnt
    addVec(1, 'h02, 0, 'h00, 1, 0, 'h00,  1, 'h02, 0, 0, 0, 'hA6, 'h01);
    addVec(1, 'h02, 0, 'h00, 1, 0, 'h00,  1, 'h02, 0, 0, 0, 'hA6, 'h01);
    addVec(1, 'h02, 0, 'h00, 1, 0, 'h00,  1, 'h02, 0, 0, 0, 'hA6, 'h01);
    addVec(1, 'h02, 1, 'hA5, 1, 0, 'h00,  1, 'h02, 1, 0, 0, 'hA6, 'h01);
    // decoder stalls 5 cycles: no request, ir stable at 0xA5, stray ack ignored
    addVec(1, 'h03, 0, 'h00, 0, 0, 'h00,  0, 'h02, 0, 0, 1, 'hA5, 'h02);
    addVec(1, 'h03, 1, 'hEE, 0, 0, 'h00,  0, 'h03, 0, 0, 1, 'hA5, 'h02);
    addVec(1, 'h03, 0, 'h00, 0, 0, 'h00,  0, 'h03, 0, 0, 1, 'hA5, 'h02);
    addVec(1, 'h03, 0, 'h00, 0, 0, 'h00,  0, 'h03, 0, 0, 1, 'hA5, 'h02);
    addVec(1, 'h03, 0, 'h00, 0, 0, 'h00,  0, 'h03, 0, 0, 1, 'hA5, 'h02);
    addVec(1, 'h03, 0, 'h00, 1, 0, 'h00,  0, 'h03, 0, 0, 1, 'hA5, 'h02);
    // fetches of 0x03 and 0x04
    addVec(1, 'h03, 1, 'h10, 1, 0, 'h00,  1, 'h03, 1, 0, 0, 'hA5, 'h02);
    addVec(1, 'h04, 0, 'h00, 1, 0, 'h00,  0, 'h03, 0, 0, 1, 'h10, 'h03);
    addVec(1, 'h04, 1, 'h11, 1, 0, 'h00,  1, 'h04, 1, 0, 0, 'h10, 'h03);
    addVec(1, 'h05, 0, 'h00, 1, 0, 'h00,  0, 'h04, 0, 0, 1, 'h11, 'h04);
    // branch to 0x40 during unacked fetch of 0x05: drain, discard, refetch 0x40
    addVec(1, 'h05, 0, 'h00, 1, 1, 'h40,  1, 'h05, 0, 1, 0, 'h11, 'h04);
    addVec(1, 'h40, 0, 'h00, 1, 0, 'h40,  1, 'h05, 0, 0, 0, 'h11, 'h04);
    addVec(1, 'h40, 1, 'h55, 1, 0, 'h40,  1, 'h05, 0, 0, 0, 'h11, 'h04);
    addVec(1, 'h40, 0, 'h00, 1, 0, 'h40,  0, 'h05, 0, 0, 0, 'h11, 'h04);
    // branch coinciding with ack and ready: no pc_cnt, data dropped
    addVec(1, 'h40, 1, 'h66, 1, 1, 'h40,  1, 'h40, 0, 1, 0, 'h11, 'h04);
    addVec(1, 'h40, 0, 'h00, 1, 0, 'h40,  0, 'h40, 0, 0, 0, 'h11, 'h04);
    addVec(1, 'h40, 1, 'h77, 1, 0, 'h40,  1, 'h40, 1, 0, 0, 'h11, 'h04);
    // flush beats acceptance in S_HOLD, redirect to 0xFF
    addVec(1, 'h41, 0, 'h00, 1, 1, 'hFF,  0, 'h40, 0, 1, 1, 'h77, 'h40);
    addVec(1, 'hFF, 0, 'h00, 1, 0, 'hFF,  0, 'h41, 0, 0, 0, 'h77, 'h40);
    // fetch at 0xFF, next request wraps to 0x00
    addVec(1, 'hFF, 1, 'h88, 1, 0, 'hFF,  1, 'hFF, 1, 0, 0, 'h77, 'h40);
    addVec(1, 'h00, 0, 'h00, 1, 0, 'hFF,  0, 'hFF, 0, 0, 1, 'h88, 'hFF);
    addVec(1, 'h00, 0, 'h00, 1, 0, 'hFF,  1, 'h00, 0, 0, 0, 'h88, 'hFF);
    // branch into S_DRAIN, then a second branch while draining stays in S_DRAIN
    addVec(1, 'h00, 0, 'h00, 1, 1, 'h20,  1, 'h00, 0, 1, 0, 'h88, 'hFF);
    addVec(1, 'h20, 0, 'h00, 1, 1, 'h30,  1, 'h00, 0, 1, 0, 'h88, 'hFF);
    addVec(1, 'h30, 0, 'h00, 1, 0, 'h30,  1, 'h00, 0, 0, 0, 'h88, 'hFF);
    // reset mid-drain: everything back to reset values, restart at 0x00
    addVec(0, 'h00, 0, 'h00, 1, 0, 'h30,  0, 'h00, 0, 0, 0, 'h00, 'h00);
    addVec(1, 'h00, 0, 'h00, 1, 0, 'h30,  0, 'h00, 0, 0, 0, 'h00, 'h00);
    addVec(1, 'h00, 1, 'h99, 1, 0, 'h30,  1, 'h00, 1, 0, 0, 'h00, 'h00);
    addVec(1, 'h01, 0, 'h00, 1, 0, 'h30,  0, 'h00, 0, 0, 1, 'h99, 'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i),
                  {vecs[i].expReq, vecs[i].expAddr, vecs[i].expCnt, vecs[i].expLd,
                   vecs[i].tgt, vecs[i].expIv, vecs[i].expIr, vecs[i].expIrPc});
    end

    // Hand sequence: asynchronous reset dropped in the middle of an acked fetch.
    @(negedge clk);
    pc = 8'h01; mem_ack = 1'b1; mem_rdata = 8'hBB; ir_ready = 1'b1;
    br_valid = 1'b0; br_target = 8'h30;
    #1;
    checkOutput("fetch_before_async_reset",
                {1'b1, 8'h01, 1'b1, 1'b0, 8'h30, 1'b0, 8'h99, 8'h00});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_abort",
                {1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 8'h00, 8'h00});
    @(posedge clk);
    #1;
    checkOutput("held_in_reset",
                {1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 8'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
